// File: rtl/mnist_pkg.sv
// Shared constants, pixel type, feeder state encoding and quantizer for the
// MNIST front end.
package mnist_pkg;

    localparam int IMG_W = 28;
    localparam int OUT_W = IMG_W / 2;
    localparam int NPIX  = OUT_W * OUT_W;

    typedef logic [1:0] pix2_t;

    typedef enum logic [1:0] {
        FILL   = 2'd0,
        WAIT   = 2'd1,
        START  = 2'd2,
        STREAM = 2'd3
    } state_e;

    // Sum of four 8-bit pixels -> mean[7:6]; the top two sum bits are exactly that.
    function automatic pix2_t quantize(input logic [9:0] sum);
        return sum[9:8];
    endfunction

endpackage

// File: rtl/mnist_frame_buf.sv
// Pooled-frame store: one synchronous write port, one asynchronous read port.
module mnist_frame_buf
    import mnist_pkg::*;
#(
    parameter int DEPTH = mnist_pkg::NPIX
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  pix2_t                    wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output pix2_t                    rd_data
);

    pix2_t mem_r [DEPTH];

    // Write port, used only while filling.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_r[rd_addr];

endmodule

// File: rtl/mnist_pool_feeder.sv
// Accepts a raster image, 2x2 average-pools and quantizes it into a frame
// store, then hands the frame to mnist_top with a start pulse.
module mnist_pool_feeder #(
    parameter int IMG_W = mnist_pkg::IMG_W
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_pixel,
    input  logic       mnist_busy,
    output logic       start,
    output logic [1:0] pixel_out,
    output logic       frame_loaded
);
    import mnist_pkg::*;

    localparam int OUT_W = IMG_W / 2;
    localparam int NPIX  = OUT_W * OUT_W;
    localparam int RW    = $clog2(IMG_W);
    localparam int KW    = $clog2(NPIX);
    localparam logic [RW-1:0] LAST_IDX = RW'(IMG_W - 1);
    localparam logic [KW-1:0] LAST_K   = KW'(NPIX - 1);

    state_e          state_r, state_nx_s;
    logic [RW-1:0]   row_r, row_nx_s, col_r, col_nx_s;
    logic [KW-1:0]   k_r, k_nx_s;
    logic [7:0]      prev_r;
    logic [8:0]      linebuf_r [OUT_W];
    logic            start_r, frame_loaded_r;
    pix2_t           pixel_out_r, rd_data_s;
    logic            xfer_s, wr_en_s;
    logic [9:0]      sum_s;
    logic [KW-1:0]   wr_addr_s;
    logic [RW-2:0]   half_col_s;

    assign in_ready     = (state_r == FILL) && !rst;
    assign xfer_s       = in_valid && in_ready;
    assign start        = start_r;
    assign pixel_out    = pixel_out_r;
    assign frame_loaded = frame_loaded_r;

    assign half_col_s = col_r[RW-1:1];
    assign sum_s      = {1'b0, linebuf_r[half_col_s]} + {2'b00, prev_r} + {2'b00, in_pixel};
    assign wr_en_s    = xfer_s && row_r[0] && col_r[0];
    assign wr_addr_s  = KW'(row_r[RW-1:1]) * KW'(OUT_W) + KW'(half_col_s);

    // State, counters and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r        <= FILL;
            row_r          <= '0;
            col_r          <= '0;
            k_r            <= '0;
            start_r        <= 1'b0;
            frame_loaded_r <= 1'b0;
            pixel_out_r    <= 2'd0;
        end else begin
            state_r        <= state_nx_s;
            row_r          <= row_nx_s;
            col_r          <= col_nx_s;
            k_r            <= k_nx_s;
            start_r        <= (state_nx_s == START);
            frame_loaded_r <= (state_nx_s != FILL);
            pixel_out_r    <= (state_nx_s == STREAM) ? rd_data_s : 2'd0;
        end
    end

    // Horizontal pair sums from even rows wait in linebuf for the odd row below.
    always_ff @(posedge clk) begin
        if (xfer_s) begin
            if (!col_r[0]) begin
                prev_r <= in_pixel;
            end
            if (!row_r[0] && col_r[0]) begin
                linebuf_r[half_col_s] <= {1'b0, prev_r} + {1'b0, in_pixel};
            end
        end
    end

    // Next-state and counter decode.
    always_comb begin
        state_nx_s = state_r;
        row_nx_s   = row_r;
        col_nx_s   = col_r;
        k_nx_s     = k_r;
        case (state_r)
            FILL: begin
                if (xfer_s) begin
                    if (col_r == LAST_IDX) begin
                        col_nx_s = '0;
                        if (row_r == LAST_IDX) begin
                            row_nx_s   = '0;
                            state_nx_s = WAIT;
                        end else begin
                            row_nx_s = row_r + RW'(1);
                        end
                    end else begin
                        col_nx_s = col_r + RW'(1);
                    end
                end else begin
                    state_nx_s = FILL;
                end
            end
            WAIT: begin
                if (!mnist_busy) begin
                    state_nx_s = START;
                end else begin
                    state_nx_s = WAIT;
                end
            end
            START: begin
                state_nx_s = STREAM;
                k_nx_s     = '0;
            end
            STREAM: begin
                if (k_r == LAST_K) begin
                    state_nx_s = FILL;
                    k_nx_s     = '0;
                    row_nx_s   = '0;
                    col_nx_s   = '0;
                end else begin
                    k_nx_s = k_r + KW'(1);
                end
            end
            default: begin
                state_nx_s = FILL;
            end
        endcase
    end

    mnist_frame_buf #(
        .DEPTH (NPIX)
    ) u_frame_buf (
        .clk     (clk),
        .wr_en   (wr_en_s),
        .wr_addr (wr_addr_s),
        .wr_data (quantize(sum_s)),
        .rd_addr (k_nx_s),
        .rd_data (rd_data_s)
    );

endmodule

// File: tb/tb_mnist_pool_feeder.sv
// Directed, table-driven bench for mnist_pool_feeder.
module tb_mnist_pool_feeder;
    import mnist_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_pixel;
    logic       mnist_busy;
    logic       start;
    logic [1:0] pixel_out;
    logic       frame_loaded;

    always #5 clk = ~clk;

    mnist_pool_feeder dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_pixel     (in_pixel),
        .mnist_busy   (mnist_busy),
        .start        (start),
        .pixel_out    (pixel_out),
        .frame_loaded (frame_loaded)
    );

    typedef struct {
        logic [7:0] p00;
        logic [7:0] p01;
        logic [7:0] p10;
        logic [7:0] p11;
        logic [1:0] q;
    } vec_t;

    vec_t       vecs [8];
    logic [7:0] img [IMG_W][IMG_W];
    logic [1:0] exp_pix [NPIX];
    logic [1:0] got_pix [NPIX];
    logic [1:0] ref_pix [NPIX];
    int         n_tests = 0;
    int         n_fail  = 0;

    task automatic chk(input string name, input int got, input int expv);
        n_tests++;
        if (got != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, got, expv);
        end
    endtask

    task automatic fill_tile(input logic [7:0] p00, input logic [7:0] p01,
                             input logic [7:0] p10, input logic [7:0] p11);
        for (int r = 0; r < IMG_W; r++)
            for (int c = 0; c < IMG_W; c++)
                img[r][c] = (r % 2 == 0) ? ((c % 2 == 0) ? p00 : p01)
                                         : ((c % 2 == 0) ? p10 : p11);
    endtask

    task automatic fill_gradient();
        for (int r = 0; r < IMG_W; r++)
            for (int c = 0; c < IMG_W; c++)
                img[r][c] = 8'((r * 37 + c * 11) % 256);
    endtask

    task automatic fill_position();
        for (int r = 0; r < IMG_W; r++)
            for (int c = 0; c < IMG_W; c++)
                img[r][c] = (r >= 2 && r <= 3 && c >= 26) ? 8'd255 : 8'd0;
        for (int k = 0; k < NPIX; k++)
            exp_pix[k] = (k == 27) ? 2'd3 : 2'd0;
    endtask

    // Reference: mean of each 2x2 block, then its top two bits.
    task automatic model_frame();
        int s;
        for (int k = 0; k < NPIX; k++) begin
            s = int'(img[2*(k/OUT_W)][2*(k%OUT_W)])     + int'(img[2*(k/OUT_W)][2*(k%OUT_W)+1])
              + int'(img[2*(k/OUT_W)+1][2*(k%OUT_W)])   + int'(img[2*(k/OUT_W)+1][2*(k%OUT_W)+1]);
            exp_pix[k] = 2'((s / 4) / 64);
        end
    endtask

    task automatic run_frame(input bit bp, input int busy_cycles, input int abort_k);
        int idx = 0;
        int cyc = 0;
        bit v, rdy;
        while (idx < IMG_W * IMG_W && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            rdy      = in_ready;
            v        = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            in_valid = v;
            in_pixel = img[idx / IMG_W][idx % IMG_W];
            if (v && rdy) idx++;
        end
        chk("fill_count", idx, IMG_W * IMG_W);
        if (idx != IMG_W * IMG_W) return;
        @(negedge clk);
        in_valid = 1'b0;
        chk("wait_in_ready", int'(in_ready), 0);
        chk("wait_frame_loaded", int'(frame_loaded), 1);
        chk("wait_start", int'(start), 0);
        for (int i = 0; i < busy_cycles; i++) begin
            @(negedge clk);
            chk("busy_start", int'(start), 0);
            chk("busy_in_ready", int'(in_ready), 0);
            chk("busy_frame_loaded", int'(frame_loaded), 1);
        end
        mnist_busy = 1'b0;
        @(negedge clk);
        chk("start_pulse", int'(start), 1);
        chk("start_pixel_out", int'(pixel_out), 0);
        for (int k = 0; k < NPIX; k++) begin
            @(negedge clk);
            if (k == abort_k) begin
                rst = 1'b1;
                #1;
                chk("rst_start", int'(start), 0);
                chk("rst_pixel_out", int'(pixel_out), 0);
                chk("rst_frame_loaded", int'(frame_loaded), 0);
                chk("rst_in_ready", int'(in_ready), 0);
                @(negedge clk);
                rst = 1'b0;
                #1;
                chk("post_rst_in_ready", int'(in_ready), 1);
                return;
            end
            got_pix[k] = pixel_out;
            chk($sformatf("pix[%0d]", k), int'(pixel_out), int'(exp_pix[k]));
            chk("stream_start", int'(start), 0);
        end
        @(negedge clk);
        chk("end_in_ready", int'(in_ready), 1);
        chk("end_frame_loaded", int'(frame_loaded), 0);
        chk("end_pixel_out", int'(pixel_out), 0);
    endtask

    initial begin
        vecs[0] = '{8'd255, 8'd255, 8'd255, 8'd255, 2'd3};
        vecs[1] = '{8'd64,  8'd64,  8'd64,  8'd63,  2'd0};
        vecs[2] = '{8'd64,  8'd64,  8'd64,  8'd64,  2'd1};
        vecs[3] = '{8'd128, 8'd128, 8'd128, 8'd127, 2'd1};
        vecs[4] = '{8'd192, 8'd192, 8'd192, 8'd192, 2'd3};
        vecs[5] = '{8'd0,   8'd0,   8'd0,   8'd0,   2'd0};
        vecs[6] = '{8'd200, 8'd200, 8'd0,   8'd0,   2'd1};
        vecs[7] = '{8'd10,  8'd250, 8'd130, 8'd122, 2'd2};

        rst        = 1'b1;
        in_valid   = 1'b0;
        in_pixel   = 8'd0;
        mnist_busy = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_in_ready", int'(in_ready), 0);
        chk("reset_start", int'(start), 0);
        chk("reset_pixel_out", int'(pixel_out), 0);
        chk("reset_frame_loaded", int'(frame_loaded), 0);
        rst = 1'b0;
        #1;
        chk("release_in_ready", int'(in_ready), 1);

        for (int i = 0; i < 8; i++) begin
            fill_tile(vecs[i].p00, vecs[i].p01, vecs[i].p10, vecs[i].p11);
            for (int k = 0; k < NPIX; k++) exp_pix[k] = vecs[i].q;
            run_frame(1'b0, 0, -1);
        end

        // Continuous vs. throttled input must give the same stream.
        fill_gradient();
        model_frame();
        run_frame(1'b0, 0, -1);
        for (int k = 0; k < NPIX; k++) ref_pix[k] = got_pix[k];
        run_frame(1'b1, 0, -1);
        for (int k = 0; k < NPIX; k++)
            chk($sformatf("bp_vs_cont[%0d]", k), int'(got_pix[k]), int'(ref_pix[k]));

        fill_position();
        mnist_busy = 1'b1;
        run_frame(1'b0, 100, -1);

        fill_gradient();
        model_frame();
        run_frame(1'b0, 0, 50);
        fill_position();
        run_frame(1'b0, 0, -1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
